// File: rtl/rsv_stable_issue_pkg.sv
// Shared types for the stable-pipe reservation station: bus widths, scoreboard
// request bundle, queue entry layout and the operand-readiness helper.
package rsv_stable_issue_pkg;

  localparam int unsigned I_BL_EX_PIP   = 3;
  localparam int unsigned I_BL_MARC_REG = 6;
  localparam int unsigned I_BL_MARC_PIP = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rsv_state_e;

  typedef struct packed {
    logic [I_BL_EX_PIP-1:0] search_pip;
    logic                   available;
    logic                   req;
  } COM_SCBREQ_STABLE;

  typedef struct packed {
    logic                     valid;
    logic [I_BL_EX_PIP-1:0]   pip;
    logic [I_BL_MARC_REG-1:0] rd;
    logic [I_BL_MARC_REG-1:0] rs1;
    logic [I_BL_MARC_REG-1:0] rs2;
    logic                     rdy1;
    logic                     rdy2;
  } RSV_ENTRY_STABLE;

  // Source is ready if flagged, if it is preg 0, or if it is being written back now.
  function automatic logic src_ready(input logic                     rdy,
                                     input logic [I_BL_MARC_REG-1:0] rs,
                                     input logic                     wb_valid,
                                     input logic [I_BL_MARC_REG-1:0] wb_preg);
    return rdy || (rs == '0) || (wb_valid && (rs == wb_preg));
  endfunction

endpackage

// File: rtl/rsv_oldest_ready_sel.sv
// Priority select: reports whether any request bit is set and the index of the lowest one.
module rsv_oldest_ready_sel #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N-1:0]     req,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/rsv_stable_issue.sv
// Reservation-station issue controller for stable pipes: compacting age queue,
// wakeup tracking, oldest-ready select and scoreboard handshake.
// Optional RSV_DISPATCH_BYPASS_EN lets a ready dispatch into an empty queue issue directly.
module rsv_stable_issue
  import rsv_stable_issue_pkg::*;
#(
  parameter logic [I_BL_MARC_PIP-1:0] RSV_ID = '0,
  parameter int unsigned              DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [I_BL_EX_PIP-1:0]         disp_pip,
  input  logic [I_BL_MARC_REG-1:0]       disp_rd,
  input  logic [I_BL_MARC_REG-1:0]       disp_rs1,
  input  logic [I_BL_MARC_REG-1:0]       disp_rs2,
  input  logic                           disp_rs1_rdy,
  input  logic                           disp_rs2_rdy,
  input  logic                           wb_valid,
  input  logic [I_BL_MARC_REG-1:0]       wb_preg,
  output logic [I_BL_EX_PIP-1:0]         scb_search_pip,
  input  logic                           scb_available,
  output logic                           scb_req,
  output logic                           iss_valid,
  output logic [I_BL_EX_PIP-1:0]         iss_pip,
  output logic [I_BL_MARC_REG-1:0]       iss_rd,
  output logic [I_BL_MARC_REG-1:0]       iss_rs1,
  output logic [I_BL_MARC_REG-1:0]       iss_rs2,
  output logic [I_BL_MARC_PIP-1:0]       iss_rsv,
  input  logic                           flush,
  output logic [$clog2(DEPTH):0]         occupancy
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = $clog2(DEPTH);

  rsv_state_e              state_q, state_n;
  RSV_ENTRY_STABLE         entries_q [DEPTH];
  RSV_ENTRY_STABLE         woken     [DEPTH];
  RSV_ENTRY_STABLE         entries_n [DEPTH];
  RSV_ENTRY_STABLE         disp_entry;
  COM_SCBREQ_STABLE        scb;
  logic [OCC_W-1:0]        occ_q, occ_n, wr_idx;
  logic [DEPTH-1:0]        ready_vec;
  logic                    sel_found;
  logic [IDX_W-1:0]        sel_idx;
  logic                    full, byp_cand, cand_valid;
  logic                    iss_fire, q_remove, q_write, disp_acc;
  logic [I_BL_EX_PIP-1:0]  cand_pip;
  logic [I_BL_MARC_REG-1:0] cand_rd, cand_rs1, cand_rs2;

  assign full      = (occ_q == OCC_W'(DEPTH));
  assign occupancy = occ_q;
  assign iss_rsv   = RSV_ID;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready_vec[i] = entries_q[i].valid && entries_q[i].rdy1 && entries_q[i].rdy2;
    end
  end

  rsv_oldest_ready_sel #(
    .N     (DEPTH),
    .IDX_W (IDX_W)
  ) u_sel (
    .req   (ready_vec),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // Captured form of the incoming instruction, including same-cycle wakeup.
  always_comb begin
    disp_entry       = '0;
    disp_entry.valid = 1'b1;
    disp_entry.pip   = disp_pip;
    disp_entry.rd    = disp_rd;
    disp_entry.rs1   = disp_rs1;
    disp_entry.rs2   = disp_rs2;
    disp_entry.rdy1  = src_ready(disp_rs1_rdy, disp_rs1, wb_valid, wb_preg);
    disp_entry.rdy2  = src_ready(disp_rs2_rdy, disp_rs2, wb_valid, wb_preg);
  end

`ifdef RSV_DISPATCH_BYPASS_EN
  assign byp_cand = (occ_q == '0) && (state_q == RUN) && !full && disp_valid
                    && disp_entry.rdy1 && disp_entry.rdy2;
`else
  assign byp_cand = 1'b0;
`endif

  assign cand_valid = sel_found || byp_cand;

  always_comb begin
    cand_pip = disp_entry.pip;
    cand_rd  = disp_entry.rd;
    cand_rs1 = disp_entry.rs1;
    cand_rs2 = disp_entry.rs2;
    if (sel_found) begin
      cand_pip = entries_q[sel_idx].pip;
      cand_rd  = entries_q[sel_idx].rd;
      cand_rs1 = entries_q[sel_idx].rs1;
      cand_rs2 = entries_q[sel_idx].rs2;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_n;
  end

  // FSM: next state; FLUSH lasts exactly one cycle
  always_comb begin
    state_n = state_q;
    case (state_q)
      RUN:     if (flush) state_n = FLUSH;
      FLUSH:   state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // FSM: outputs and scoreboard handshake
  always_comb begin
    scb            = '0;
    disp_ready     = 1'b0;
    scb.available  = scb_available;
    scb.search_pip = cand_valid ? cand_pip : '0;
    case (state_q)
      RUN: begin
        disp_ready = !full;
        scb.req    = cand_valid && scb.available && !flush;
      end
      default: ;
    endcase
    scb_search_pip = scb.search_pip;
    scb_req        = scb.req;
  end

  assign iss_fire = scb.req;
  assign q_remove = iss_fire && sel_found;
  assign disp_acc = disp_valid && disp_ready && !flush;
  assign q_write  = disp_acc && !(iss_fire && !sel_found);
  assign wr_idx   = occ_q - OCC_W'(q_remove);
  assign occ_n    = flush ? '0 : occ_q + OCC_W'(disp_acc) - OCC_W'(iss_fire);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = entries_q[i];
      if (wb_valid && entries_q[i].valid) begin
        if (entries_q[i].rs1 == wb_preg) woken[i].rdy1 = 1'b1;
        if (entries_q[i].rs2 == wb_preg) woken[i].rdy2 = 1'b1;
      end
    end
  end

  // Queue update: remove-and-compact, then append at the new tail, flush last.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) entries_n[i] = woken[i];
    if (q_remove) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) entries_n[i] = woken[i+1];
      end
      entries_n[DEPTH-1] = '0;
    end
    if (q_write) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (OCC_W'(i) == wr_idx) entries_n[i] = disp_entry;
      end
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries_n[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
      occ_q     <= '0;
      iss_valid <= 1'b0;
      iss_pip   <= '0;
      iss_rd    <= '0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_n[i];
      occ_q     <= occ_n;
      iss_valid <= iss_fire;
      if (iss_fire) begin
        iss_pip <= cand_pip;
        iss_rd  <= cand_rd;
        iss_rs1 <= cand_rs1;
        iss_rs2 <= cand_rs2;
      end
    end
  end

endmodule

// File: tb/tb_rsv_stable_issue.sv
// Directed bench for rsv_stable_issue (DEPTH=4, RSV_ID=0); follows RSV_DISPATCH_BYPASS_EN.
module tb_rsv_stable_issue;
  import rsv_stable_issue_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     disp_valid, disp_ready;
  logic [I_BL_EX_PIP-1:0]   disp_pip;
  logic [I_BL_MARC_REG-1:0] disp_rd, disp_rs1, disp_rs2;
  logic                     disp_rs1_rdy, disp_rs2_rdy;
  logic                     wb_valid;
  logic [I_BL_MARC_REG-1:0] wb_preg;
  logic [I_BL_EX_PIP-1:0]   scb_search_pip;
  logic                     scb_available, scb_req;
  logic                     iss_valid;
  logic [I_BL_EX_PIP-1:0]   iss_pip;
  logic [I_BL_MARC_REG-1:0] iss_rd, iss_rs1, iss_rs2;
  logic [I_BL_MARC_PIP-1:0] iss_rsv;
  logic                     flush;
  logic [2:0]               occupancy;

  int n_vec = 0;
  int n_err = 0;

  rsv_stable_issue dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .disp_valid     (disp_valid),
    .disp_ready     (disp_ready),
    .disp_pip       (disp_pip),
    .disp_rd        (disp_rd),
    .disp_rs1       (disp_rs1),
    .disp_rs2       (disp_rs2),
    .disp_rs1_rdy   (disp_rs1_rdy),
    .disp_rs2_rdy   (disp_rs2_rdy),
    .wb_valid       (wb_valid),
    .wb_preg        (wb_preg),
    .scb_search_pip (scb_search_pip),
    .scb_available  (scb_available),
    .scb_req        (scb_req),
    .iss_valid      (iss_valid),
    .iss_pip        (iss_pip),
    .iss_rd         (iss_rd),
    .iss_rs1        (iss_rs1),
    .iss_rs2        (iss_rs2),
    .iss_rsv        (iss_rsv),
    .flush          (flush),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    disp_valid   = 1'b0;
    disp_pip     = '0;
    disp_rd      = '0;
    disp_rs1     = '0;
    disp_rs2     = '0;
    disp_rs1_rdy = 1'b0;
    disp_rs2_rdy = 1'b0;
    wb_valid     = 1'b0;
    wb_preg      = '0;
    flush        = 1'b0;
  endtask

  task automatic drive_disp(input logic [2:0] pip, input logic [5:0] rd,
                            input logic [5:0] rs1, input logic [5:0] rs2);
    disp_valid = 1'b1;
    disp_pip   = pip;
    disp_rd    = rd;
    disp_rs1   = rs1;
    disp_rs2   = rs2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    scb_available = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst occupancy", 32'(occupancy), 0);
    chk("rst iss_valid", 32'(iss_valid), 0);
    chk("rst iss_rd", 32'(iss_rd), 0);
    chk("rst iss_pip", 32'(iss_pip), 0);
    chk("rst iss_rsv", 32'(iss_rsv), 0);
    chk("rst disp_ready", 32'(disp_ready), 1);
    chk("rst scb_req", 32'(scb_req), 0);
    chk("rst search_pip", 32'(scb_search_pip), 0);

    // single ready instruction
    drive_disp(3'd2, 6'd5, 6'd0, 6'd0);
    scb_available = 1'b1;
    #1;
`ifdef RSV_DISPATCH_BYPASS_EN
    chk("t1 bypass req", 32'(scb_req), 1);
    tick();
    idle();
`else
    chk("t1 no req at dispatch", 32'(scb_req), 0);
    tick();
    idle();
    #1;
    chk("t1 occupancy", 32'(occupancy), 1);
    chk("t1 search_pip", 32'(scb_search_pip), 2);
    chk("t1 scb_req", 32'(scb_req), 1);
    tick();
`endif
    chk("t1 iss_valid", 32'(iss_valid), 1);
    chk("t1 iss_rd", 32'(iss_rd), 5);
    chk("t1 iss_pip", 32'(iss_pip), 2);
    chk("t1 occ drained", 32'(occupancy), 0);
    tick();
    chk("t1 iss_valid pulse", 32'(iss_valid), 0);

    // older waiting entry is overtaken by a younger ready one
    drive_disp(3'd1, 6'd10, 6'd7, 6'd0);
    tick();
    drive_disp(3'd3, 6'd11, 6'd0, 6'd0);
    #1;
    chk("t2 A not ready", 32'(scb_req), 0);
    tick();
    idle();
    wb_valid = 1'b1;
    wb_preg  = 6'd7;
    #1;
    chk("t2 B req", 32'(scb_req), 1);
    chk("t2 B pip", 32'(scb_search_pip), 3);
    tick();
    idle();
    chk("t2 B issued", 32'(iss_rd), 11);
    #1;
    chk("t2 A req", 32'(scb_req), 1);
    chk("t2 A pip", 32'(scb_search_pip), 1);
    tick();
    chk("t2 A issued", 32'(iss_rd), 10);
    chk("t2 A iss_valid", 32'(iss_valid), 1);
    chk("t2 occ", 32'(occupancy), 0);

    // fill, reject overflow, drain in order
    scb_available = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_disp(3'(k), 6'(20 + k), 6'd0, 6'd0);
      #1;
      chk("t3 disp_ready", 32'(disp_ready), 1);
      tick();
    end
    drive_disp(3'd7, 6'd30, 6'd0, 6'd0);
    #1;
    chk("t3 full ready", 32'(disp_ready), 0);
    chk("t3 full occ", 32'(occupancy), 4);
    tick();
    idle();
    chk("t3 overflow ignored", 32'(occupancy), 4);
    scb_available = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3 drain req", 32'(scb_req), 1);
      chk("t3 drain pip", 32'(scb_search_pip), k);
      if (k == 0) chk("t3 no full bypass", 32'(disp_ready), 0);
      tick();
      chk("t3 drain iss_rd", 32'(iss_rd), 20 + k);
    end
    #1;
    chk("t3 empty req", 32'(scb_req), 0);
    chk("t3 empty occ", 32'(occupancy), 0);
    chk("t3 empty pip", 32'(scb_search_pip), 0);

    // wakeup in the dispatch cycle is captured
    scb_available = 1'b0;
    drive_disp(3'd4, 6'd12, 6'd0, 6'd9);
    wb_valid = 1'b1;
    wb_preg  = 6'd9;
    tick();
    idle();
    scb_available = 1'b1;
    #1;
    chk("t4 req", 32'(scb_req), 1);
    chk("t4 pip", 32'(scb_search_pip), 4);
    tick();
    chk("t4 iss_rd", 32'(iss_rd), 12);
    chk("t4 iss_rs2", 32'(iss_rs2), 9);

    // flush beats a same-cycle issue
    scb_available = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_disp(3'd1, 6'(40 + k), 6'd0, 6'd0);
      tick();
    end
    idle();
    chk("t5 occ3", 32'(occupancy), 3);
    scb_available = 1'b1;
    flush = 1'b1;
    #1;
    chk("t5 flush req", 32'(scb_req), 0);
    tick();
    idle();
    drive_disp(3'd2, 6'd50, 6'd0, 6'd0);
    #1;
    chk("t5 occ0", 32'(occupancy), 0);
    chk("t5 iss_valid", 32'(iss_valid), 0);
    chk("t5 disp_ready", 32'(disp_ready), 0);
    chk("t5 req idle", 32'(scb_req), 0);
    tick();
    idle();
    chk("t5 disp ignored", 32'(occupancy), 0);
    chk("t5 iss_valid2", 32'(iss_valid), 0);
    chk("t5 ready again", 32'(disp_ready), 1);

    // reset mid-operation overrides dispatch
    scb_available = 1'b0;
    drive_disp(3'd3, 6'd60, 6'd0, 6'd0);
    tick();
    rst_n = 1'b0;
    drive_disp(3'd3, 6'd61, 6'd0, 6'd0);
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    chk("t6 rst occ", 32'(occupancy), 0);
    chk("t6 rst req", 32'(scb_req), 0);
    chk("t6 rst ready", 32'(disp_ready), 1);

    // ready dispatch into an empty queue
    scb_available = 1'b1;
    drive_disp(3'd5, 6'd33, 6'd0, 6'd0);
    #1;
`ifdef RSV_DISPATCH_BYPASS_EN
    chk("t7 bypass req", 32'(scb_req), 1);
    chk("t7 bypass pip", 32'(scb_search_pip), 5);
    tick();
    idle();
    chk("t7 occ stays 0", 32'(occupancy), 0);
    chk("t7 iss_rd", 32'(iss_rd), 33);
`else
    chk("t7 no bypass", 32'(scb_req), 0);
    tick();
    idle();
    chk("t7 occ 1", 32'(occupancy), 1);
    tick();
    chk("t7 iss_rd", 32'(iss_rd), 33);
    chk("t7 occ 0", 32'(occupancy), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
